// File: rtl/pico_io_responder.sv
// Purpose: pico I/O port responder with wait states, display/LED registers and a held interrupt request.
// Latency: strobe sampled at edge E0 -> port_ready high in the cycle after edge E0+WAIT_CYCLES; writes are visible the following cycle.
// Backpressure: none; a strobe arriving while a transfer is in flight is dropped, never queued.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   port_addr, port_wr_data       address/data sampled with a strobe
//   write_strobe, read_strobe     one-cycle requests (both together = write)
//   port_rd_data, port_ready      read data and one-cycle completion pulse
//   int_event_n, int_ack, int_req asynchronous button in, acknowledge in, held request out
//   switches                      static input port
//   disp_word, led_reg            display (4 hex digits) and LED registers
//   int_miss_cnt                  saturating count of interrupts lost while one was pending
module pico_io_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  BASE_ADDR   = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  port_addr,
    input  logic [7:0]  port_wr_data,
    input  logic        write_strobe,
    input  logic        read_strobe,
    output logic [7:0]  port_rd_data,
    output logic        port_ready,
    input  logic        int_event_n,
    input  logic        int_ack,
    output logic        int_req,
    input  logic [7:0]  switches,
    output logic [15:0] disp_word,
    output logic [7:0]  led_reg,
    output logic [3:0]  int_miss_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [7:0] lat_addr;
    logic [7:0] lat_data;
    logic       lat_we;
    logic [7:0] lat_off;
    logic [7:0] rd_mux;
    logic       strobe;
    logic       commit;
    logic       status_clr;
    logic [1:0] int_sync;
    logic       int_hist;
    logic       int_fall;

    assign strobe  = write_strobe | read_strobe;
    // Wrapping subtraction: offset 0..4 selects a register, anything else is unmapped.
    assign lat_off = lat_addr - BASE_ADDR;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (strobe) begin
                    state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: ready pulse, read data only during a read completion, write commit
    always_comb begin
        port_ready   = (state == S_DONE);
        port_rd_data = (state == S_DONE && !lat_we) ? rd_mux : 8'h00;
        commit       = (state == S_DONE) && lat_we;
    end

    assign status_clr = commit && (lat_off == 8'd4);

    // Request capture and wait-state counter; strobes outside IDLE are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 4'd0;
            lat_addr <= 8'h00;
            lat_data <= 8'h00;
            lat_we   <= 1'b0;
        end else if (state == S_IDLE) begin
            if (strobe) begin
                wait_cnt <= WAIT_INIT;
                lat_addr <= port_addr;
                lat_data <= port_wr_data;
                lat_we   <= write_strobe;
            end
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (lat_off)
            8'd0:    rd_mux = disp_word[7:0];
            8'd1:    rd_mux = disp_word[15:8];
            8'd2:    rd_mux = led_reg;
            8'd3:    rd_mux = switches;
            8'd4:    rd_mux = {int_miss_cnt, 2'b00, int_req, 1'b0};
            default: rd_mux = 8'h00;
        endcase
    end

    // Writable registers; commit happens on the edge that ends DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_word <= 16'h0000;
            led_reg   <= 8'h00;
        end else if (commit) begin
            case (lat_off)
                8'd0:    disp_word[7:0]  <= lat_data;
                8'd1:    disp_word[15:8] <= lat_data;
                8'd2:    led_reg         <= lat_data;
                default: ;
            endcase
        end
    end

    // Button synchronizer plus history flop; idle level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_sync <= 2'b11;
            int_hist <= 1'b1;
        end else begin
            int_sync <= {int_sync[0], int_event_n};
            int_hist <= int_sync[1];
        end
    end

    assign int_fall = int_hist & ~int_sync[1];

    // A fall coinciding with an ack keeps the request up and is not a miss.
    // A STATUS clear overrides a same-cycle miss increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_req      <= 1'b0;
            int_miss_cnt <= 4'd0;
        end else begin
            if (int_fall) begin
                if (!int_req) begin
                    int_req <= 1'b1;
                end else if (!int_ack && int_miss_cnt != 4'hF) begin
                    int_miss_cnt <= int_miss_cnt + 4'd1;
                end
            end else if (int_ack) begin
                int_req <= 1'b0;
            end
            if (status_clr) begin
                int_miss_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_pico_io_responder.sv
// Purpose: self-checking bench for pico_io_responder: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: model predicts port_ready at strobe edge + W, commit one edge later, int_req two edges after first low sample.
// Backpressure: model drops strobes until the cycle after port_ready.
module tb_pico_io_responder;

    localparam int         W    = 2;
    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  port_addr = 8'h00;
    logic [7:0]  port_wr_data = 8'h00;
    logic        write_strobe = 1'b0;
    logic        read_strobe = 1'b0;
    logic [7:0]  port_rd_data;
    logic        port_ready;
    logic        int_event_n = 1'b1;
    logic        int_ack = 1'b0;
    logic        int_req;
    logic [7:0]  switches = 8'h00;
    logic [15:0] disp_word;
    logic [7:0]  led_reg;
    logic [3:0]  int_miss_cnt;

    pico_io_responder #(
        .WAIT_CYCLES(W),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .port_addr    (port_addr),
        .port_wr_data (port_wr_data),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .port_rd_data (port_rd_data),
        .port_ready   (port_ready),
        .int_event_n  (int_event_n),
        .int_ack      (int_ack),
        .int_req      (int_req),
        .switches     (switches),
        .disp_word    (disp_word),
        .led_reg      (led_reg),
        .int_miss_cnt (int_miss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc = 0;          // index of the next clock edge to be modelled
    int         m_base = 0;       // button samples before this edge read as high
    bit         samp [0:65535];   // button level sampled at each edge
    bit         m_pend = 0;       // a transfer has been accepted and not yet retired
    int         m_r = 0;          // edge after which port_ready is high
    bit         m_we = 0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_wd = 8'h00;
    logic [7:0] m_reg [3];        // DISP_LO, DISP_HI, LED
    bit         m_req = 0;
    int         m_miss = 0;

    function automatic bit samp_at(input int j);
        return (j < m_base) ? 1'b1 : samp[j];
    endfunction

    function automatic logic [7:0] rd_model(input logic [7:0] addr);
        logic [7:0] off;
        logic [3:0] mc;
        off = addr - BASE;
        mc  = 4'(m_miss);
        case (off)
            8'd0:    return m_reg[0];
            8'd1:    return m_reg[1];
            8'd2:    return m_reg[2];
            8'd3:    return switches;
            8'd4:    return {mc, 2'b00, m_req, 1'b0};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0;
        m_reg[0] = 8'h00;
        m_reg[1] = 8'h00;
        m_reg[2] = 8'h00;
        m_req  = 0;
        m_miss = 0;
        m_base = cyc;
    endtask

    // Effect of edge 'cyc' given the inputs currently applied.
    task automatic model_edge();
        bit         fall;
        bit         was_idle;
        bit         clr;
        logic [7:0] off;
        fall     = samp_at(cyc - 3) && !samp_at(cyc - 2);
        was_idle = !m_pend;
        clr      = 0;
        if (m_pend && cyc == m_r + 1) begin
            off = m_addr - BASE;
            if (m_we) begin
                if (off < 8'd3) m_reg[off[1:0]] = m_wd;
                if (off == 8'd4) clr = 1;
            end
            m_pend = 0;
        end
        if (fall) begin
            if (!m_req) m_req = 1;
            else if (!int_ack && m_miss < 15) m_miss++;
        end else if (int_ack) begin
            m_req = 0;
        end
        if (clr) m_miss = 0;
        if (was_idle && (write_strobe || read_strobe)) begin
            m_pend = 1;
            m_r    = cyc + W;
            m_we   = write_strobe;
            m_addr = port_addr;
            m_wd   = port_wr_data;
        end
        samp[cyc] = int_event_n;
        cyc++;
    endtask

    task automatic score();
        bit         exp_rdy;
        logic [7:0] exp_rd;
        exp_rdy = m_pend && (m_r == cyc - 1);
        exp_rd  = (exp_rdy && !m_we) ? rd_model(m_addr) : 8'h00;
        chk("port_ready",   32'(port_ready),   32'(exp_rdy));
        chk("port_rd_data", 32'(port_rd_data), 32'(exp_rd));
        chk("int_req",      32'(int_req),      32'(m_req));
        chk("disp_word",    32'(disp_word),    32'({m_reg[1], m_reg[0]}));
        chk("led_reg",      32'(led_reg),      32'(m_reg[2]));
        chk("int_miss_cnt", 32'(int_miss_cnt), 32'(m_miss));
    endtask

    // One clock: model the coming edge, wait for it, then compare just after it.
    task automatic tick();
        if (reset_n) model_edge();
        @(posedge clk);
        #1;
        if (reset_n) score();
    endtask

    task automatic xfer(input bit we, input logic [7:0] off, input logic [7:0] wd,
                        output logic [7:0] rd);
        int n;
        write_strobe = we;
        read_strobe  = !we;
        port_addr    = BASE + off;
        port_wr_data = wd;
        tick();
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        n = 0;
        while (!port_ready && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(W));
        rd = port_rd_data;
        tick();
        chk("ready_one_cycle", 32'(port_ready), 32'd0);
    endtask

    task automatic fall_pulse(input int lo, input int hi);
        int_event_n = 1'b0;
        repeat (lo) tick();
        int_event_n = 1'b1;
        repeat (hi) tick();
    endtask

    initial begin
        logic [7:0] rd;
        int         cnt;
        bit         s;

        m_reg[0] = 8'h00;
        m_reg[1] = 8'h00;
        m_reg[2] = 8'h00;
        #2;
        reset_n = 1'b0;
        model_reset();
        repeat (2) tick();
        chk("rst_ready",  32'(port_ready),   32'd0);
        chk("rst_rd",     32'(port_rd_data), 32'd0);
        chk("rst_req",    32'(int_req),      32'd0);
        chk("rst_disp",   32'(disp_word),    32'd0);
        chk("rst_led",    32'(led_reg),      32'd0);
        chk("rst_miss",   32'(int_miss_cnt), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Display writes
        xfer(1, 8'd0, 8'hA5, rd);
        xfer(1, 8'd1, 8'h3C, rd);
        chk("disp_3ca5", 32'(disp_word), 32'h3CA5);

        // Switch read, unmapped read, ignored write to SWITCHES
        switches = 8'h5A;
        xfer(0, 8'd3, 8'h00, rd);
        chk("rd_switches", 32'(rd), 32'h5A);
        xfer(0, 8'd7, 8'h00, rd);
        chk("rd_unmapped", 32'(rd), 32'h00);
        xfer(1, 8'd3, 8'h11, rd);
        chk("wr_sw_disp", 32'(disp_word), 32'h3CA5);
        chk("wr_sw_led",  32'(led_reg),   32'h00);
        xfer(0, 8'd3, 8'h00, rd);
        chk("rd_switches2", 32'(rd), 32'h5A);

        // Second strobe during WAIT is dropped
        write_strobe = 1'b1;
        port_addr    = BASE + 8'd2;
        port_wr_data = 8'hFF;
        tick();
        port_addr    = BASE;
        port_wr_data = 8'h77;
        tick();
        write_strobe = 1'b0;
        cnt = 0;
        repeat (8) begin
            tick();
            if (port_ready) cnt++;
        end
        chk("single_ready", 32'(cnt), 32'd1);
        chk("led_ff",       32'(led_reg), 32'hFF);
        chk("drop_disp",    32'(disp_word), 32'h3CA5);

        // Interrupt latency, misses, STATUS, ack, clear
        int_event_n = 1'b0;
        tick();
        chk("irq_e0", 32'(int_req), 32'd0);
        tick();
        chk("irq_e1", 32'(int_req), 32'd0);
        tick();
        chk("irq_e2", 32'(int_req), 32'd1);
        tick();
        int_event_n = 1'b1;
        repeat (4) tick();
        repeat (2) fall_pulse(4, 4);
        chk("miss_2", 32'(int_miss_cnt), 32'd2);
        xfer(0, 8'd4, 8'h00, rd);
        chk("status_22", 32'(rd), 32'h22);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("ack_clears", 32'(int_req), 32'd0);
        xfer(1, 8'd4, 8'h00, rd);
        chk("status_clr", 32'(int_miss_cnt), 32'd0);

        // Fall coincident with ack, then saturation
        fall_pulse(4, 4);
        chk("req_again", 32'(int_req), 32'd1);
        int_event_n = 1'b0;
        tick();
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("coinc_req",  32'(int_req),      32'd1);
        chk("coinc_miss", 32'(int_miss_cnt), 32'd0);
        tick();
        int_event_n = 1'b1;
        repeat (4) tick();
        repeat (17) fall_pulse(3, 3);
        chk("miss_sat", 32'(int_miss_cnt), 32'd15);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        xfer(1, 8'd4, 8'h00, rd);

        // Reset during WAIT aborts the write
        write_strobe = 1'b1;
        port_addr    = BASE;
        port_wr_data = 8'h99;
        tick();
        write_strobe = 1'b0;
        tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("abort_ready", 32'(port_ready), 32'd0);
        chk("abort_disp",  32'(disp_word),  32'h0000);
        repeat (2) tick();
        reset_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            tick();
            if (port_ready) cnt++;
        end
        chk("abort_no_ready", 32'(cnt), 32'd0);
        chk("abort_disp2",    32'(disp_word), 32'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            s = ($urandom_range(0, 3) == 0);
            write_strobe = s && ($urandom_range(0, 1) == 0);
            read_strobe  = s && ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) port_addr = 8'($urandom);
            else                            port_addr = BASE + 8'($urandom_range(0, 7));
            port_wr_data = 8'($urandom);
            if ($urandom_range(0, 15) == 0) switches = 8'($urandom);
            if ($urandom_range(0, 4) == 0)  int_event_n = ~int_event_n;
            int_ack = ($urandom_range(0, 11) == 0);
            tick();
        end
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        int_ack      = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
